len_req_arbiter: RTL and testbench
==================================

Name: len_req_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one leading-one length engine (64-bit in, 8-bit length out, one-cycle start pulse, one-cycle end pulse) among NUM_REQ requesters.
- Captures a requester's operand, pulses the engine start, and waits for the end pulse.
- Returns the length to the winning requester and then advances the fairness pointer.
- Sits between the client blocks and the single length engine instance.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
IDX_W, 2, grant index width = clog2(NUM_REQ); set by instantiator
TIMEOUT_CYC, 16, WAIT-state watchdog limit in cycles (used only with the optional feature); legal range 2..255

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request; held until matching req_ready pulse
req_num  in  64*NUM_REQ  operand bus; requester i uses bits [64*i+63:64*i]
req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse
resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
resp_len  out  8  result length; valid when any resp_valid bit is high
resp_err  out  1  watchdog error flag, qualified by resp_valid
busy  out  1  high in any state other than IDLE
eng_start  out  1  engine start pulse
eng_num  out  64  engine operand
eng_len  in  8  engine length result
eng_end  in  1  engine done pulse

Behaviour:
- Reset: synchronous, active-high, sampled at the rising edge of clk. All outputs go to 0, state goes to IDLE, rr_ptr goes to 0, latched grant and operand registers go to 0.
- Reset mid-operation: the transaction is abandoned with no response. An eng_end that arrives after reset is ignored because it is outside WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any req_valid bit is set, select the winner as the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ. Latch the winner index and its req_num slice, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: one cycle. eng_start=1, req_ready[grant]=1, eng_num=latched operand. Go to WAIT.
  - WAIT: when eng_end=1, latch eng_len into resp_len, clear resp_err, go to RESP. Otherwise stay in WAIT.
  - RESP: one cycle. resp_valid[grant]=1. Set rr_ptr = (grant+1) mod NUM_REQ. Go to IDLE.
- eng_num holds the latched operand from ISSUE through RESP. Its value is don't-care in IDLE.
- eng_end is ignored in IDLE, ISSUE and RESP.
- resp_len and resp_err hold their last value until the next latch.
- Timing with the standard engine (end pulse one cycle after start):
  - request seen in IDLE at cycle T
  - req_ready and eng_start at T+1
  - eng_end at T+2
  - resp_valid at T+3
  - back in IDLE at T+4, so the next request can be seen at T+4
  - sustained throughput: one operation per 4 cycles
- The operand is captured at the IDLE edge. A requester that drops req_valid or changes req_num after that edge, but before its req_ready pulse, does not corrupt the transaction.
- Fairness: the last winner has the lowest priority on the next arbitration. No requester waits more than NUM_REQ-1 grants while its req_valid is held.
- rr_ptr wraps from NUM_REQ-1 to 0.
- All outputs are registered or decoded from state registers only. There is no combinational path from req_* or eng_* inputs to outputs.

Optional Feature:
- Macro: LEN_ARB_WATCHDOG_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle with eng_end=0.
  - When the counter reaches TIMEOUT_CYC, the block goes to RESP with resp_len=0 and resp_err=1.
  - An eng_end arriving in the same cycle as the limit takes priority: normal result, resp_err=0.
- Not defined:
  - WAIT waits indefinitely.
  - resp_err is tied to 0 and no counter is instantiated.

Test Plan:
1. Single request: NUM_REQ=4, req_valid=4'b0100, req_num[2]=64'h9. Required: req_ready=4'b0100 at T+1 with eng_start=1 and eng_num=64'h9; resp_valid=4'b0100 at T+3 with resp_len=8'd4 and resp_err=0.
2. Round-robin fairness: all four req_valid held high continuously from reset. Required: grant order 0,1,2,3,0, and resp_valid pulses exactly 4 cycles apart.
3. Contention after a win: grant to requester 3, then requests 0 and 3 both valid. Required: requester 0 wins the next grant (rr_ptr wrapped to 0).
4. Zero operand: req_num=64'h0. Required: resp_len=0, resp_err=0, FSM completes normally.
5. Reset mid-operation: assert rst in WAIT, then deliver a stale eng_end the cycle after reset deasserts. Required: no resp_valid, busy=0, rr_ptr=0, next request follows the timing of test 1.
6. Watchdog (LEN_ARB_WATCHDOG_EN, TIMEOUT_CYC=16): hold eng_end=0. Required: resp_valid with resp_len=0 and resp_err=1 after 16 WAIT cycles, then IDLE. With the macro undefined, busy stays high.

Source files
------------

// File: rtl/len_req_arbiter.sv
// len_req_arbiter: round-robin sequencer sharing one leading-one length
// engine (64-bit operand in, 8-bit length out) among NUM_REQ requesters.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid       per-requester request, held until its req_ready pulse
//   req_num         operand bus, requester i on [64*i+63:64*i]
//   req_ready       one-hot, one-cycle acceptance pulse (ISSUE)
//   resp_valid      one-hot, one-cycle result pulse (RESP)
//   resp_len        result length, valid with resp_valid
//   resp_err        watchdog error flag, qualified by resp_valid
//   busy            high whenever the FSM is not IDLE
//   eng_start       one-cycle engine start pulse
//   eng_num         engine operand, held from ISSUE through RESP
//   eng_len         engine length result
//   eng_end         engine done pulse, only honoured in WAIT
//
// Optional: define LEN_ARB_WATCHDOG_EN to add a WAIT-state timeout of
// TIMEOUT_CYC cycles that returns resp_len=0 with resp_err=1.
module len_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [64*NUM_REQ-1:0] req_num,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [7:0]            resp_len,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  eng_start,
    output logic [63:0]           eng_num,
    input  logic [7:0]            eng_len,
    input  logic                  eng_end
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [63:0]        r_num;
    logic [7:0]         r_len;
    logic [NUM_REQ-1:0] r_ready;
    logic [NUM_REQ-1:0] r_rvalid;
    logic               r_start;
    logic               r_busy;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_cand;

    // Index addition modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        int t;
        t = (v >= NUM_REQ) ? v - NUM_REQ : v;
        return t[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] f_onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // First requester at or above r_ptr, wrapping; the previous winner
    // sits at r_ptr-1 and is therefore scanned last.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = f_wrap(int'(r_ptr) + i);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

`ifdef LEN_ARB_WATCHDOG_EN
    logic [7:0] r_wd;
    logic       r_err;
`else
    logic [7:0] w_unused_to;
    assign w_unused_to = 8'(TIMEOUT_CYC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_num    <= '0;
            r_len    <= '0;
            r_ready  <= '0;
            r_rvalid <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef LEN_ARB_WATCHDOG_EN
            r_wd     <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_num   <= req_num[64*w_win +: 64];
                        r_ready <= f_onehot(w_win);
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ready <= '0;
                    r_start <= 1'b0;
`ifdef LEN_ARB_WATCHDOG_EN
                    r_wd    <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A real end pulse wins over a simultaneous timeout.
                    if (eng_end) begin
                        r_len    <= eng_len;
                        r_rvalid <= f_onehot(r_grant);
`ifdef LEN_ARB_WATCHDOG_EN
                        r_err    <= 1'b0;
`endif
                        r_state  <= S_RESP;
                    end
`ifdef LEN_ARB_WATCHDOG_EN
                    else if (r_wd == 8'(TIMEOUT_CYC - 1)) begin
                        r_len    <= '0;
                        r_err    <= 1'b1;
                        r_rvalid <= f_onehot(r_grant);
                        r_state  <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_rvalid <= '0;
                    r_busy   <= 1'b0;
                    r_ptr    <= f_wrap(int'(r_grant) + 1);
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_rvalid;
    assign resp_len   = r_len;
    assign busy       = r_busy;
    assign eng_start  = r_start;
    assign eng_num    = r_num;
`ifdef LEN_ARB_WATCHDOG_EN
    assign resp_err   = r_err;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_len_req_arbiter.sv
// tb_len_req_arbiter: directed checks of len_req_arbiter with a
// behavioural leading-one engine (end pulse one cycle after start).
module tb_len_req_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_num = '0;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [7:0]   resp_len;
    logic         resp_err;
    logic         busy;
    logic         eng_start;
    logic [63:0]  eng_num;
    logic [7:0]   eng_len = '0;
    logic         eng_end;

    logic m_end   = 1'b0;
    logic f_end   = 1'b0;
    logic auto_en = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    len_req_arbiter #(
        .NUM_REQ(4),
        .IDX_W(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_num(req_num),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_len(resp_len),
        .resp_err(resp_err),
        .busy(busy),
        .eng_start(eng_start),
        .eng_num(eng_num),
        .eng_len(eng_len),
        .eng_end(eng_end)
    );

    function automatic logic [7:0] ref_len(input logic [63:0] v);
        for (int i = 63; i >= 0; i--)
            if (v[i]) return 8'(i + 1);
        return 8'd0;
    endfunction

    always @(posedge clk) begin
        m_end   <= eng_start & auto_en;
        eng_len <= ref_len(eng_num);
    end
    assign eng_end = m_end | f_end;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (req_ready !== 4'b0 || resp_valid !== 4'b0) begin
            errors++;
            $display("FAIL rst_hs ready %b rvalid %b want 0",
                     req_ready, resp_valid);
        end
        checks++;
        if (resp_len !== 8'd0 || resp_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_st len %0d err %b busy %b want 0",
                     resp_len, resp_err, busy);
        end
        checks++;
        if (eng_start !== 1'b0 || eng_num !== 64'h0) begin
            errors++;
            $display("FAIL rst_eng start %b num %h want 0",
                     eng_start, eng_num);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_num[128 +: 64] = 64'h9;
        req_valid = 4'b0100;
        step();
        checks++;
        if (req_ready !== 4'b0100 || eng_start !== 1'b1
            || eng_num !== 64'h9) begin
            errors++;
            $display("FAIL t1_issue ready %b start %b num %h want 0100 1 9",
                     req_ready, eng_start, eng_num);
        end
        req_valid = 4'b0;
        req_num[128 +: 64] = 64'hFFFF;
        step();
        checks++;
        if (req_ready !== 4'b0 || eng_num !== 64'h9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_wait ready %b num %h busy %b want 0 9 1",
                     req_ready, eng_num, busy);
        end
        step();
        checks++;
        if (resp_valid !== 4'b0100 || resp_len !== 8'd4
            || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL t1_resp rvalid %b len %0d err %b want 0100 4 0",
                     resp_valid, resp_len, resp_err);
        end
        step();
        checks++;
        if (resp_valid !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle rvalid %b busy %b want 0 0",
                     resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int last = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            req_num[64*i +: 64] = 64'h1 << (8*i + 3);
        req_valid = 4'b1111;
        step();
        rst = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (resp_valid !== 4'b0 && n < 5) begin
                checks++;
                if (resp_valid !== (4'b0001 << exp_id[n])
                    || resp_len !== 8'(8*exp_id[n] + 4)) begin
                    errors++;
                    $display("FAIL rr_grant%0d rvalid %b len %0d want id %0d len %0d",
                             n, resp_valid, resp_len, exp_id[n],
                             8*exp_id[n] + 4);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last != 4) begin
                        errors++;
                        $display("FAIL rr_gap%0d got %0d want 4",
                                 n, c - last);
                    end
                end
                last = c;
                n++;
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count got %0d want 5", n);
        end
        req_valid = 4'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        bit seen;
        req_num[192 +: 64] = 64'hFF;
        req_num[0 +: 64] = 64'h1_0000;
        req_valid = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            if (req_ready !== 4'b0) seen = 1'b1;
        end
        checks++;
        if (!seen || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first ready %b want 1000", req_ready);
        end
        req_valid = 4'b1001;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step();
            if (req_ready !== 4'b0) seen = 1'b1;
        end
        checks++;
        if (!seen || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_next ready %b want 0001", req_ready);
        end
        req_valid = 4'b0;
        step();
        step();
        checks++;
        if (resp_valid !== 4'b0001 || resp_len !== 8'd17) begin
            errors++;
            $display("FAIL wrap_resp rvalid %b len %0d want 0001 17",
                     resp_valid, resp_len);
        end
        step();
    endtask

    task automatic test_zero();
        req_num[0 +: 64] = 64'h0;
        req_valid = 4'b0001;
        step();
        checks++;
        if (req_ready !== 4'b0001 || eng_num !== 64'h0) begin
            errors++;
            $display("FAIL zero_issue ready %b num %h want 0001 0",
                     req_ready, eng_num);
        end
        req_valid = 4'b0;
        step();
        step();
        checks++;
        if (resp_valid !== 4'b0001 || resp_len !== 8'd0
            || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_resp rvalid %b len %0d err %b want 0001 0 0",
                     resp_valid, resp_len, resp_err);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        req_num[64 +: 64] = 64'h9;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || resp_valid !== 4'b0) begin
            errors++;
            $display("FAIL mid_wait busy %b rvalid %b want 1 0",
                     busy, resp_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        f_end = 1'b1;
        step();
        f_end = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (resp_valid !== 4'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale%0d rvalid %b busy %b want 0 0",
                         c, resp_valid, busy);
            end
            step();
        end
        auto_en = 1'b1;
        req_num[0 +: 64] = 64'h80;
        req_valid = 4'b0011;
        step();
        checks++;
        if (req_ready !== 4'b0001 || eng_num !== 64'h80) begin
            errors++;
            $display("FAIL mid_ptr ready %b num %h want 0001 80",
                     req_ready, eng_num);
        end
        req_valid = 4'b0;
        step();
        step();
        checks++;
        if (resp_valid !== 4'b0001 || resp_len !== 8'd8) begin
            errors++;
            $display("FAIL mid_resp rvalid %b len %0d want 0001 8",
                     resp_valid, resp_len);
        end
        step();
    endtask

    task automatic test_watchdog();
        auto_en = 1'b0;
        req_num[128 +: 64] = 64'h5;
        req_valid = 4'b0100;
        step();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wd_issue ready %b want 0100", req_ready);
        end
        req_valid = 4'b0;
        for (int c = 0; c < 16; c++) step();
        checks++;
        if (resp_valid !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_hold rvalid %b busy %b want 0 1",
                     resp_valid, busy);
        end
`ifdef LEN_ARB_WATCHDOG_EN
        step();
        checks++;
        if (resp_valid !== 4'b0100 || resp_len !== 8'd0
            || resp_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_resp rvalid %b len %0d err %b want 0100 0 1",
                     resp_valid, resp_len, resp_err);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle busy %b want 0", busy);
        end
`else
        for (int c = 0; c < 14; c++) step();
        checks++;
        if (resp_valid !== 4'b0 || busy !== 1'b1 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_off rvalid %b busy %b err %b want 0 1 0",
                     resp_valid, busy, resp_err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        auto_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_zero();
        test_reset_mid();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
